// File: rtl/gray_unpack.sv
// Receive-side unpacker: takes one 32-bit word of four Gray-coded bytes and
// emits them one at a time as binary bytes, flagging the last byte of each word.
module gray_unpack #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [15:0] word_cnt
);

  // Handshake rule on both ports: a beat moves on a rising edge only when
  // valid and ready are both high; valid never drops and data never changes
  // while the beat is waiting for ready.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] hold_q, hold_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic       accept;
  logic       xfer;
  logic [1:0] lane;
  logic [7:0] gray_sel;

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    out_valid = (state_q == SHIFT);
    out_last  = out_valid & (idx_q == 2'd3);
    xfer      = out_valid & out_ready;
    // The only combinational input-to-output path: a new word may be taken
    // in the same cycle the last byte of the current word leaves.
    in_ready  = rst_n & ((state_q == IDLE) | (xfer & (idx_q == 2'd3)));
    accept    = in_valid & in_ready;

    lane      = MSB_FIRST ? ~idx_q : idx_q;
    gray_sel  = hold_q[{lane, 3'b000} +: 8];
    out_byte  = gray2bin(gray_sel);
    word_cnt  = word_cnt_q;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = in_word;
          idx_d   = 2'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else begin
            word_cnt_d = word_cnt_q + 16'd1;
            if (accept) begin
              hold_d = in_word;
              idx_d  = 2'd0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      hold_q     <= 32'd0;
      word_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_gray_unpack.sv
// Directed bench for gray_unpack: one MSB-first and one LSB-first instance
// share the same stimulus; each scenario task checks its own expectations.
module tb_gray_unpack;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_word;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready, in_ready_l;
  logic [7:0]  out_byte, out_byte_l;
  logic        out_valid, out_valid_l;
  logic        out_last, out_last_l;
  logic [15:0] word_cnt, word_cnt_l;

  int checks;
  int errors;

  gray_unpack #(.MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .word_cnt(word_cnt)
  );

  gray_unpack #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_byte(out_byte_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_last(out_last_l), .word_cnt(word_cnt_l)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_word   = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_word   = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL reset_in_ready c%0d got %b exp 0", c, in_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || out_valid_l !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid c%0d got %b/%b exp 0", c, out_valid, out_valid_l);
      end
      checks++;
      if (out_byte !== 8'h00 || out_last !== 1'b0) begin
        errors++; $display("FAIL reset_out_byte c%0d got %h last %b exp 00 last 0", c, out_byte, out_last);
      end
      checks++;
      if (word_cnt !== 16'd0) begin
        errors++; $display("FAIL reset_word_cnt c%0d got %h exp 0000", c, word_cnt);
      end
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release got in_ready %b out_valid %b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_decode(input string name, input logic [31:0] w,
                             input logic [31:0] exp_msb, input logic [31:0] exp_lsb);
    logic [7:0] em, el;
    do_reset();
    in_word   = w;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL %s_idle got in_ready %b out_valid %b exp 1 0", name, in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_word  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      em = exp_msb[31 - 8*i -: 8];
      el = exp_lsb[31 - 8*i -: 8];
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_byte !== em || out_last !== (i == 3)) begin
        errors++;
        $display("FAIL %s_msb_b%0d got v%b %h l%b exp v1 %h l%b", name, i, out_valid, out_byte, out_last, em, i == 3);
      end
      checks++;
      if (out_valid_l !== 1'b1 || out_byte_l !== el || out_last_l !== (i == 3)) begin
        errors++;
        $display("FAIL %s_lsb_b%0d got v%b %h l%b exp v1 %h l%b", name, i, out_valid_l, out_byte_l, out_last_l, el, i == 3);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || word_cnt !== 16'd1 || word_cnt_l !== 16'd1) begin
      errors++; $display("FAIL %s_end got v%b cnt %h/%h exp v0 cnt 0001", name, out_valid, word_cnt, word_cnt_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    logic [7:0]  exp_b [12];
    words = '{32'h0001_0302, 32'h80C0_FF00, 32'h0102_0408, 32'h0};
    exp_b = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h80, 8'hAA, 8'h00,
              8'h01, 8'h03, 8'h07, 8'h0F};
    do_reset();
    in_word   = words[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle_ready got %b exp 1", in_ready);
    end
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      in_word  = words[c/4 + 1];
      in_valid = (c != 11);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_byte !== exp_b[c] || out_last !== (c % 4 == 3)) begin
        errors++;
        $display("FAIL b2b_byte%0d got v%b %h l%b exp v1 %h l%b", c, out_valid, out_byte, out_last, exp_b[c], c % 4 == 3);
      end
      checks++;
      if (in_ready !== (c % 4 == 3)) begin
        errors++; $display("FAIL b2b_in_ready%0d got %b exp %b", c, in_ready, c % 4 == 3);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || word_cnt !== 16'd3) begin
      errors++; $display("FAIL b2b_end got v%b cnt %h exp v0 cnt 0003", out_valid, word_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_word   = 32'h0001_0302;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'h00) begin
      errors++; $display("FAIL bp_byte0 got v%b %h exp v1 00", out_valid, out_byte);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_word   = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_byte !== 8'h01 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d got v%b %h l%b rdy%b exp v1 01 l0 rdy0", c, out_valid, out_byte, out_last, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_byte !== 8'(i) || out_last !== (i == 3)) begin
        errors++;
        $display("FAIL bp_after_b%0d got v%b %h l%b exp v1 %h l%b", i, out_valid, out_byte, out_last, 8'(i), i == 3);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (out_valid !== 1'b0 || word_cnt !== 16'd1) begin
      errors++; $display("FAIL bp_end got v%b cnt %h exp v0 cnt 0001", out_valid, word_cnt);
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut.word_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.word_cnt_q;
    in_word   = 32'h0001_0302;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    checks++;
    if (out_last !== 1'b1 || word_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_pre got l%b cnt %h exp l1 cnt ffff", out_last, word_cnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (word_cnt !== 16'h0000) begin
      errors++; $display("FAIL wrap_cnt got %h exp 0000", word_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_word   = 32'h0001_0302;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_byte !== 8'h02) begin
      errors++; $display("FAIL midrst_pre got v%b %h exp v1 02", out_valid, out_byte);
    end
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_word  = 32'h80C0_FF00;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_byte !== 8'h00 || out_last !== 1'b0 || word_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midrst_outputs got v%b %h l%b cnt %h exp v0 00 l0 cnt 0000", out_valid, out_byte, out_last, word_cnt);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_release got rdy%b v%b exp rdy1 v0", in_ready, out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_no_bytes%0d got v%b %h exp v0", c, out_valid, out_byte);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_decode("basic", 32'h0001_0302, 32'h0001_0203, 32'h0302_0100);
    test_decode("highbit", 32'h80C0_FF00, 32'hFF80_AA00, 32'h00AA_80FF);
    test_back_to_back();
    test_backpressure();
    test_counter_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_unpack.md
# gray_unpack

Word-to-byte unpacker and Gray-to-binary decoder. It is the receive-side counterpart of the `gray` packer. It accepts one 32-bit word holding four Gray-coded bytes through a valid/ready handshake. It emits those bytes one per transfer as binary values on an 8-bit valid/ready stream, and flags the last byte of each word. The block sits between the packed 32-bit datapath and byte-wide consumers, and converts back to the 8-bit counting domain that feeds the packer.

## Interface

- `MSB_FIRST`, default 1: 1 emits `in_word[31:24]` first and `[7:0]` last; 0 emits `[7:0]` first and `[31:24]` last.

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: synchronous active-low reset, sampled on the `clk` rising edge.
- `in_word`, in, 32: four Gray-coded bytes.
- `in_valid`, in, 1: `in_word` is valid.
- `in_ready`, out, 1: block accepts `in_word` this cycle.
- `out_byte`, out, 8: decoded binary byte.
- `out_valid`, out, 1: `out_byte` is valid.
- `out_ready`, in, 1: consumer accepts `out_byte` this cycle.
- `out_last`, out, 1: `out_byte` is the 4th byte of its word.
- `word_cnt`, out, 16: number of fully emitted words, modulo 2^16.

## Operation

- The FSM has two states.
  - IDLE: no word held.
  - SHIFT: `hold[31:0]` holds a word; `idx[1:0]` selects the current byte.
- Handshakes:
  - Input accept = `in_valid & in_ready`.
  - Output transfer = `out_valid & out_ready`.
- `in_ready` = `rst_n & (state==IDLE | (out_valid & out_ready & idx==3))`.
  - This is combinational from `out_ready`.
  - This is the only comb path through the block.
- Transitions:
  - IDLE, on accept: load `hold` <= `in_word`, `idx` <= 0, go to SHIFT.
  - SHIFT, on transfer with `idx`<3: `idx` <= `idx`+1.
  - SHIFT, on transfer with `idx`==3 and an accept in the same cycle: load the new word, `idx` <= 0, stay in SHIFT. There is no bubble.
  - SHIFT, on transfer with `idx`==3 and no accept: go to IDLE.
  - SHIFT, with no transfer: all state holds.
- Byte selection:
  - With `MSB_FIRST`=1, `idx` 0..3 maps to `hold[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - With `MSB_FIRST`=0, the order is reversed.
- Gray decode of the selected byte g: b[7]=g[7]; b[i]=b[i+1]^g[i] for i=6..0.
- Output signals:
  - `out_valid` = (state==SHIFT).
  - `out_last` = `out_valid & idx==3`.
  - `out_byte` = decode(selected byte), driven from registers only.
- `word_cnt` increments on every transfer with `idx`==3 and wraps 0xFFFF -> 0x0000.
- While `out_valid` is high and `out_ready` is low, `out_byte`, `out_last` and `out_valid` hold stable. Once asserted, `out_valid` never drops without a transfer.
- `in_word` is ignored while `in_ready` is low.

## Timing

- Reset values (`rst_n` low at a rising edge):
  - state IDLE, `idx`=0, `hold`=0.
  - `out_valid`=0, `out_last`=0, `out_byte`=0x00, `word_cnt`=0.
  - `in_ready`=0 for as long as `rst_n` is low.
- Reset mid-word: the held word is discarded and no further bytes of it are emitted. In the first cycle after release, `in_ready`=1 and `out_valid`=0.
- Latency: a word accepted at edge k puts byte 0 on the outputs in the cycle after edge k.
- Throughput: with `out_ready` held at 1 and `in_valid` held at 1, one byte per cycle and 4 cycles per word, indefinitely.
- Transfers of bytes 0..3 occur at the end of consecutive cycles while `out_ready`=1.
- Simultaneous reset and handshake: reset wins; no accept and no transfer take effect.

## Test plan

- Reset check: hold `rst_n` low for 2 cycles with `in_valid`=1 -> `in_ready`=0, `out_valid`=0, `out_byte`=0x00, `word_cnt`=0 throughout.
- Basic decode: `MSB_FIRST`=1, `in_word`=0x00010302, `out_ready`=1 -> bytes 0x00, 0x01, 0x02, 0x03 on 4 consecutive cycles; `out_last` high only on 0x03; `word_cnt`=1.
- High-bit decode and order: `in_word`=0x80C0FF00.
  - With `MSB_FIRST`=1 -> 0xFF, 0x80, 0xAA, 0x00.
  - With `MSB_FIRST`=0 -> 0x00, 0xAA, 0x80, 0xFF.
- Back-to-back: stream 3 words with `in_valid` and `out_ready` constantly 1 -> 12 bytes with no gap; `in_ready` high only in the cycles with `out_last`=1 (plus the initial IDLE cycle); `word_cnt`=3.
- Backpressure: drop `out_ready` for 5 cycles while byte index 1 (0x01 of 0x00010302) is presented -> `out_byte` holds 0x01 and `out_valid`=1; `in_ready`=0; the remaining bytes 0x02, 0x03 follow after release.
- Counter wrap and mid-word reset:
  - Force 65536 words -> `word_cnt` returns to 0x0000.
  - Assert `rst_n`=0 after byte 1 of a word -> no bytes 2-3 emitted; outputs at reset values.
